// File: rtl/coreabc_ram_arbiter_pkg.sv
// coreabc_ram_pkg
// Shared definitions for the RAM arbiter slice. It holds the RAM geometry,
// the arbiter FSM encoding and the requester index constants.
// Ports: none (package).
package coreabc_ram_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 128;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   // The fill ends when the counter is about to wrap from all-ones to zero.
   localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // Bit positions of the requesters in grant and eligibility vectors
   localparam int REQ_A = 0;
   localparam int REQ_B = 1;

endpackage

// File: rtl/coreabc_ram_arbiter_if.sv
// coreabc_ram_arbiter_if
// Request/acknowledge channel between one requester and the RAM arbiter.
// Signals:
//   req    requester -> arbiter  access request, fields held until ack
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   ack    arbiter -> requester  one-cycle access-complete pulse
//   rdata  arbiter -> requester  read data, valid only with ack on a read
// Modports: master (requester side), slave (arbiter side).
interface coreabc_ram_arbiter_if;
   import coreabc_ram_pkg::*;

   logic  req;
   logic  we;
   addr_t addr;
   data_t wdata;
   logic  ack;
   data_t rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );

endinterface

// File: rtl/coreabc_ram_arbiter_rr_arb2.sv
// coreabc_rr_arb2
// Two-way round-robin grant. The grant is combinational from the eligibility
// vector and the pointer. The pointer moves only on a grant, and after reset
// it favours requester A.
// Ports:
//   pclk     in   clock
//   presetn  in   synchronous active-low reset
//   en       in   arbitration allowed this cycle
//   elig     in   [REQ_B:REQ_A] eligible requesters
//   grant    out  [REQ_B:REQ_A] one-hot grant, zero when nothing is granted
module coreabc_rr_arb2
   import coreabc_ram_pkg::*;
(
   input  logic       pclk,
   input  logic       presetn,
   input  logic       en,
   input  logic [1:0] elig,
   output logic [1:0] grant
);

   // 1: B wins a tie, 0: A wins a tie
   logic favor_b_q;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = favor_b_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         favor_b_q <= 1'b0;
      end else if (grant[REQ_A]) begin
         favor_b_q <= 1'b1;
      end else if (grant[REQ_B]) begin
         favor_b_q <= 1'b0;
      end
   end

endmodule

// File: rtl/coreabc_ram_arbiter.sv
// coreabc_ram_arbiter
// Arbiter and initialiser for the core's 128x8 synchronous-read RAM. Two
// requesters share the single write port and the single read port. At most
// one access is issued per cycle. The block can also run a hardware fill that
// writes INIT_VALUE to every location.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate A/B requests; INIT_REQ (or pending auto-init) starts a fill
// FILL  | write INIT_VALUE at the counter address, 0..127, one per cycle
//
// Parameters:
//   INIT_VALUE     byte written to every location during a fill
//   INIT_ON_RESET  1: start a fill automatically on the first cycle out of reset
// Ports:
//   pclk       in   clock for the block and the RAM
//   presetn    in   synchronous active-low reset
//   init_req   in   start a fill (ignored while busy)
//   busy       out  fill in progress
//   a_bus      slave channel of requester A (sequencer side)
//   b_bus      slave channel of requester B (APB host side)
//   ram_wd     out  RAM write data
//   ram_waddr  out  RAM write address
//   ram_raddr  out  RAM read address
//   ram_wen    out  RAM write enable
//   ram_rd     in   RAM registered read data, valid one clock after ram_raddr
module coreabc_ram_arbiter
   import coreabc_ram_pkg::*;
#(
   parameter logic [DATA_W-1:0] INIT_VALUE    = 8'h00,
   parameter bit                INIT_ON_RESET = 1'b0
)
(
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic                 init_req,
   output logic                 busy,
   coreabc_ram_arbiter_if.slave a_bus,
   coreabc_ram_arbiter_if.slave b_bus,
   output data_t                ram_wd,
   output addr_t                ram_waddr,
   output addr_t                ram_raddr,
   output logic                 ram_wen,
   input  data_t                ram_rd
);

   state_t     state_q;
   state_t     state_d;
   addr_t      cnt_q;
   addr_t      cnt_d;
   logic       auto_init_q;
   logic [1:0] ack_q;
   logic [1:0] rd_q;
   logic [1:0] req;
   logic [1:0] wr;
   logic [1:0] elig;
   logic [1:0] grant;
   logic       start_fill;
   logic       arb_en;

   assign req  = {b_bus.req, a_bus.req};
   assign wr   = {b_bus.we,  a_bus.we};

   // A requester granted last cycle is being acknowledged now, so its request
   // is still up but must not be served twice.
   assign elig = req & ~ack_q;

   // auto_init_q stands in for INIT_REQ on the first cycle out of reset.
   assign start_fill = init_req | auto_init_q;

   // A starting fill takes priority over any request. Gating with presetn
   // keeps the RAM outputs quiet while reset is held.
   assign arb_en = presetn && (state_q == ST_IDLE) && !start_fill;

   coreabc_rr_arb2 u_rr_arb2 (
      .pclk    (pclk),
      .presetn (presetn),
      .en      (arb_en),
      .elig    (elig),
      .grant   (grant)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_fill) begin
               state_d = ST_FILL;
               cnt_d   = '0;
            end
         end
         ST_FILL: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ram_wen   = 1'b0;
      ram_waddr = '0;
      ram_raddr = '0;
      ram_wd    = '0;
      if (state_q == ST_FILL) begin
         ram_wen   = 1'b1;
         ram_waddr = cnt_q;
         ram_wd    = INIT_VALUE;
      end else if (grant[REQ_A]) begin
         if (a_bus.we) begin
            ram_wen   = 1'b1;
            ram_waddr = a_bus.addr;
            ram_wd    = a_bus.wdata;
         end else begin
            ram_raddr = a_bus.addr;
         end
      end else if (grant[REQ_B]) begin
         if (b_bus.we) begin
            ram_wen   = 1'b1;
            ram_waddr = b_bus.addr;
            ram_wd    = b_bus.wdata;
         end else begin
            ram_raddr = b_bus.addr;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ack_q       <= 2'b00;
         rd_q        <= 2'b00;
         auto_init_q <= INIT_ON_RESET;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ack_q       <= grant;
         rd_q        <= grant & ~wr;
         auto_init_q <= 1'b0;
      end
   end

   assign busy = (state_q == ST_FILL);

   // The read port is never used by the fill, so ram_rd is still valid for a
   // read acknowledged in the first cycle of a fill.
   assign a_bus.ack   = ack_q[REQ_A];
   assign b_bus.ack   = ack_q[REQ_B];
   assign a_bus.rdata = rd_q[REQ_A] ? ram_rd : '0;
   assign b_bus.rdata = rd_q[REQ_B] ? ram_rd : '0;

endmodule
